param_queue: RTL
================

// Module: param_queue
// PURPOSE
//  Parametrised circular-buffer FIFO; successor to the fixed 8x10 single-RW queue.
//  - Separate write and read enables, both accepted in the same cycle.
//  - Occupancy count, almost-full/almost-empty flags, overflow/underflow pulses, synchronous flush.
//  - Selectable registered-read or first-word-fall-through (FWFT) output.
//  Sits between producer and consumer blocks on the CLK domain; pointers exported for debug.
// PARAMETERS
//  DATA_WIDTH  10  data word width
//  ADDR_WIDTH  3   RAM address width; DEPTH = 2**ADDR_WIDTH (default 8)
//  AF_THRESH   6   Almost_Full asserted when Count >= AF_THRESH (1..DEPTH)
//  AE_THRESH   2   Almost_Empty asserted when Count <= AE_THRESH (0..DEPTH-1)
//  FWFT        0   0 = registered read; 1 = head word presented without a read strobe
// PORTS
//  CLK           in   1             clock, rising edge
//  Reset         in   1             synchronous, active-high reset
//  Flush         in   1             synchronous empty request (no memory clear)
//  Wr_En         in   1             write request
//  DataIn        in   DATA_WIDTH    write data
//  Rd_En         in   1             read request
//  DataOut       out  DATA_WIDTH    read data
//  Empty         out  1             Count == 0
//  Full          out  1             Count == DEPTH
//  Almost_Empty  out  1             Count <= AE_THRESH
//  Almost_Full   out  1             Count >= AF_THRESH
//  Overflow      out  1             1-cycle pulse: previous-cycle write rejected
//  Underflow     out  1             1-cycle pulse: previous-cycle read rejected
//  Count         out  ADDR_WIDTH+1  stored words, 0..DEPTH
//  Front_Addr    out  ADDR_WIDTH+1  read pointer (MSB = wrap bit)
//  Back_Addr     out  ADDR_WIDTH+1  write pointer (MSB = wrap bit)
// BEHAVIOUR
//  - Reset (highest priority) clears the following; Wr_En, Rd_En and Flush are ignored that cycle:
//    - Front_Addr, Back_Addr, Count, DataOut, Overflow and Underflow go to 0.
//    - Empty = 1, Almost_Empty = 1, Full = 0, Almost_Full = 0.
//    - RAM contents are not cleared.
//  - Flush (priority below Reset) does the same, except DataOut holds in FWFT=0.
//    Wr_En and Rd_En are ignored in a flush cycle.
//  - Accept rules, evaluated on the state before the edge:
//    - rd_ok = Rd_En & ~Empty.
//    - wr_ok = Wr_En & (~Full | rd_ok).
//    - At Full with read and write together, both are accepted and Count holds.
//    - At Empty with read and write together, the write is accepted, the read is rejected and Underflow pulses.
//  - Write: mem[Back_Addr[ADDR_WIDTH-1:0]] <= DataIn; Back_Addr increments mod 2**(ADDR_WIDTH+1).
//  - Read: Front_Addr increments mod 2**(ADDR_WIDTH+1).
//  - Count update: Count <= Count + wr_ok - rd_ok.
//  - Flags are decoded from registered state (zero-latency vs Count):
//    - Empty when Front_Addr == Back_Addr.
//    - Full when the MSBs differ and the low bits are equal.
//  - Overflow <= Wr_En & ~wr_ok; Underflow <= Rd_En & ~rd_ok. Both are high for exactly one cycle per rejection.
//  - Rejected operations change no pointer, count or RAM word.
//  - FWFT=0:
//    - DataOut <= mem[Front] on an accepted read, so data appears 1 cycle after the Rd_En edge.
//    - Otherwise DataOut holds.
//    - A same-cycle write to the slot being read does not corrupt the read word (read-before-write).
//  - FWFT=1:
//    - DataOut = mem[Front] combinationally; it is 0 while Empty.
//    - Rd_En acknowledges the shown word, and the next word shows after that edge.
//    - Write-to-Empty shows the word 1 cycle after the write edge.
//  - Wrap-around: the low address bits roll DEPTH-1 -> 0; the wrap bit disambiguates full from empty.
// TESTING (defaults: DEPTH 8, DATA_WIDTH 10, AF 6, AE 2, FWFT 0 unless noted)
//  1. Reset, then write 15,17,20,29,24,29,30 on consecutive cycles.
//     -> Count = 7, Almost_Full = 1 from the 6th write, Empty = 0, Full = 0.
//     -> Read 7 times: DataOut returns 15..30 in order, Empty = 1 after the last read.
//  2. Fill to 8 words, then 1 more write.
//     -> Full = 1, Overflow pulses 1 cycle, Back_Addr stays 4'b1000, Count = 8.
//     -> Read on Empty: Underflow pulses and DataOut holds.
//  3. Full, then Wr_En & Rd_En together with DataIn = 99.
//     -> Count stays 8, the oldest word is output, and 99 is read last.
//  4. Pointer wrap: 3 cycles of write-then-read for 12 cycles.
//     -> Front_Addr and Back_Addr pass 4'b0111 -> 4'b1000.
//     -> Data order is preserved and no false Full/Empty occurs.
//  5. Load 5 words, then assert Flush with Wr_En = 1.
//     -> Count = 0 and Empty = 1 next cycle, no write is taken.
//     -> Repeat with Reset mid-burst: all outputs return to their reset values.
//  6. FWFT=1: write 42 to an empty queue.
//     -> DataOut = 42 the cycle after, with no Rd_En.
//     -> Rd_En with 2 words queued advances to the 2nd word the next cycle.

Source files
------------

// File: rtl/param_queue.sv
// Parametrised circular-buffer FIFO with occupancy flags, reject pulses,
// synchronous flush and selectable registered / first-word-fall-through read.
module param_queue #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned AF_THRESH  = 6,
  parameter int unsigned AE_THRESH  = 2,
  parameter int unsigned FWFT       = 0
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  Flush,
  input  logic                  Wr_En,
  input  logic [DATA_WIDTH-1:0] DataIn,
  input  logic                  Rd_En,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  Empty,
  output logic                  Full,
  output logic                  Almost_Empty,
  output logic                  Almost_Full,
  output logic                  Overflow,
  output logic                  Underflow,
  output logic [ADDR_WIDTH:0]   Count,
  output logic [ADDR_WIDTH:0]   Front_Addr,
  output logic [ADDR_WIDTH:0]   Back_Addr
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned PW    = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] AF_C = PW'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C = PW'(AE_THRESH);

  logic [ADDR_WIDTH:0]   front_q, front_d;
  logic [ADDR_WIDTH:0]   back_q, back_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic empty_c, full_c, rd_ok_c, wr_ok_c, wr_take_c;
  logic [DATA_WIDTH-1:0] head_c;

  // Flags come straight from the registered pointers; the wrap bit separates full from empty.
  assign empty_c = (front_q == back_q);
  assign full_c  = (front_q[ADDR_WIDTH] != back_q[ADDR_WIDTH]) &&
                   (front_q[ADDR_WIDTH-1:0] == back_q[ADDR_WIDTH-1:0]);
  assign head_c  = mem_q[front_q[ADDR_WIDTH-1:0]];

  // Accept decisions, next pointers, count, read word and reject pulses.
  always_comb begin
    rd_ok_c   = Rd_En & ~empty_c;
    wr_ok_c   = Wr_En & (~full_c | rd_ok_c);
    wr_take_c = wr_ok_c & ~Flush & ~Reset;
    front_d   = front_q;
    back_d    = back_q;
    count_d   = count_q;
    dout_d    = dout_q;
    ovf_d     = Wr_En & ~wr_ok_c;
    udf_d     = Rd_En & ~rd_ok_c;
    if (Flush) begin
      front_d = '0;
      back_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (wr_ok_c) back_d = back_q + PW'(1);
      if (rd_ok_c) begin
        front_d = front_q + PW'(1);
        dout_d  = head_c;
      end
      case ({wr_ok_c, rd_ok_c})
        2'b10:   count_d = count_q + PW'(1);
        2'b01:   count_d = count_q - PW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state with synchronous reset taking priority over everything.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      front_q <= '0;
      back_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      front_q <= front_d;
      back_q  <= back_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage array; never cleared, read word above is sampled before this write lands.
  always_ff @(posedge CLK) begin
    if (wr_take_c) mem_q[back_q[ADDR_WIDTH-1:0]] <= DataIn;
  end

  // Output decode; FWFT shows the head word directly and forces zero while empty.
  assign DataOut      = (FWFT != 0) ? (empty_c ? '0 : head_c) : dout_q;
  assign Empty        = empty_c;
  assign Full         = full_c;
  assign Almost_Empty = (count_q <= AE_C);
  assign Almost_Full  = (count_q >= AF_C);
  assign Overflow     = ovf_q;
  assign Underflow    = udf_q;
  assign Count        = count_q;
  assign Front_Addr   = front_q;
  assign Back_Addr    = back_q;

endmodule
